// File: rtl/cover_toggle_sched_pkg.sv
// Shared types and helpers for the toggle-coverage report scheduler.
package cover_sched_pkg;

   localparam int RPT_CNT_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      HOLD = 2'd2
   } sched_state_t;

   // Flat bit position of bit b inside hit group g.
   function automatic int flat_pos(input int g, input int b, input int src_w);
      return g * src_w + b;
   endfunction

endpackage

// File: rtl/cover_toggle_sched_rr_pick.sv
// Rotating first-set finder: lowest set request at or above i_ptr, wrapping to 0.
module cover_rr_pick #(
   parameter int TOTAL = 24,
   parameter int PTR_W = 5
) (
   input  logic [TOTAL-1:0] i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic             o_found,
   output logic [PTR_W-1:0] o_pos
);

   localparam logic [PTR_W:0] TOT_L = (PTR_W+1)'(TOTAL);

   logic [2*TOTAL-1:0] w_dbl;
   logic [TOTAL-1:0]   w_rot;
   logic [PTR_W-1:0]   w_off;
   logic [PTR_W:0]     w_sum;

   // Doubling the vector turns the wrap-around scan into a plain shift.
   assign w_dbl   = {i_req, i_req};
   assign w_rot   = w_dbl[i_ptr +: TOTAL];
   assign o_found = |w_rot;

   always_comb begin
      w_off = '0;
      for (int i = TOTAL - 1; i >= 0; i--) begin
         if (w_rot[i]) w_off = PTR_W'(i);
      end
   end

   always_comb begin
      w_sum = {1'b0, i_ptr} + {1'b0, w_off};
      if (w_sum >= TOT_L) w_sum = w_sum - TOT_L;
      o_pos = w_sum[PTR_W-1:0];
   end

endmodule

// File: rtl/cover_toggle_sched.sv
// Sticky toggle-hit bitmap drained round-robin as one valid/ready index stream.
// Define COVER_DEDUP_EN for report-once mode (each bit reported at most once per reset).
module cover_toggle_sched
   import cover_sched_pkg::*;
#(
   parameter int NUM_SRC    = 4,
   parameter int SRC_W      = 6,
   parameter int COVER_BASE = 0,
   parameter int IDX_W      = 32
) (
   input  logic                     gbl_clklk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [NUM_SRC*SRC_W-1:0] hit,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [IDX_W-1:0]         out_index,
   output logic                     busy,
   output logic [RPT_CNT_W-1:0]     rpt_count
);

   localparam int TOTAL = NUM_SRC * SRC_W;
   localparam int PTR_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

   sched_state_t         r_state;
   sched_state_t         w_state_nxt;
   logic [TOTAL-1:0]     r_pending;
   logic [PTR_W-1:0]     r_ptr;
   logic [IDX_W-1:0]     r_index;
   logic [RPT_CNT_W-1:0] r_cnt;

   logic                 w_found;
   logic [PTR_W-1:0]     w_pos;
   logic                 w_can_load;
   logic                 w_grant;
   logic                 w_accept;
   logic [TOTAL-1:0]     w_grant_mask;
   logic [TOTAL-1:0]     w_hit_eff;

   function automatic logic [RPT_CNT_W-1:0] sat_inc(input logic [RPT_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   cover_rr_pick #(
      .TOTAL (TOTAL),
      .PTR_W (PTR_W)
   ) u_pick (
      .i_req   (r_pending),
      .i_ptr   (r_ptr),
      .o_found (w_found),
      .o_pos   (w_pos)
   );

   assign out_valid  = (r_state != IDLE);
   assign out_index  = r_index;
   assign rpt_count  = r_cnt;
   assign busy       = (|r_pending) | out_valid;
   assign w_accept   = out_valid & out_ready;
   assign w_can_load = !out_valid || out_ready;
   assign w_grant    = w_can_load && w_found;

   always_comb begin
      w_grant_mask = '0;
      if (w_grant) w_grant_mask[w_pos] = 1'b1;
   end

`ifdef COVER_DEDUP_EN
   logic [TOTAL-1:0] r_covered;

   always_ff @(posedge gbl_clklk) begin
      if (!reset) r_covered <= '0;
      else        r_covered <= r_covered | w_grant_mask;
   end

   // Include this cycle's grant so a same-cycle re-hit cannot re-arm the bit.
   assign w_hit_eff = hit & ~(r_covered | w_grant_mask);
`else
   assign w_hit_eff = hit;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_grant) w_state_nxt = SEND;
         end
         SEND, HOLD: begin
            if (!out_ready)   w_state_nxt = HOLD;
            else if (w_grant) w_state_nxt = SEND;
            else              w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge gbl_clklk) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_pending <= '0;
         r_ptr     <= '0;
         r_index   <= '0;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= (r_pending & ~w_grant_mask) | (enable ? w_hit_eff : '0);
         if (w_grant) begin
            r_index <= IDX_W'(COVER_BASE) + IDX_W'(w_pos);
            r_ptr   <= (w_pos == PTR_W'(TOTAL - 1)) ? '0 : w_pos + 1'b1;
         end
         if (w_accept) r_cnt <= sat_inc(r_cnt);
      end
   end

endmodule

// File: tb/tb_cover_toggle_sched.sv
// Directed bench for cover_toggle_sched with a queue scoreboard of expected report indices.
module tb_cover_toggle_sched;
   import cover_sched_pkg::*;

   localparam int NUM_SRC = 4;
   localparam int SRC_W   = 6;
   localparam int BASE    = 100;
   localparam int TOTAL   = NUM_SRC * SRC_W;

   logic             gbl_clklk = 1'b0;
   logic             reset     = 1'b0;
   logic             enable    = 1'b1;
   logic             out_ready = 1'b1;
   logic [TOTAL-1:0] hit       = '0;
   logic             out_valid;
   logic             busy;
   logic [31:0]      out_index;
   logic [31:0]      rpt_count;

   int          total   = 0;
   int          bad     = 0;
   int          exp_cnt = 0;
   logic [31:0] sb_q[$];

   cover_toggle_sched #(
      .NUM_SRC    (NUM_SRC),
      .SRC_W      (SRC_W),
      .COVER_BASE (BASE),
      .IDX_W      (32)
   ) dut (
      .gbl_clklk (gbl_clklk),
      .reset     (reset),
      .enable    (enable),
      .hit       (hit),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_index (out_index),
      .busy      (busy),
      .rpt_count (rpt_count)
   );

   always #5 gbl_clklk = ~gbl_clklk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge gbl_clklk);
      #1;
   endtask

   task automatic push(input int idx);
      sb_q.push_back(32'(idx));
      exp_cnt++;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((busy || sb_q.size() != 0) && n < 60) begin
         tick();
         n++;
      end
      chk({tag, "_drain_in_time"}, 32'(n < 60), 32'd1);
      chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      exp_cnt = 0;
      sb_q.delete();
   endtask

   // Handshake values are stable mid-cycle; the transfer completes at the next posedge.
   always @(negedge gbl_clklk) begin
      if (reset && out_valid && out_ready) begin
         if (sb_q.size() == 0) chk("unexpected_report", out_index, 32'hFFFF_FFFF);
         else                  chk("sb_index", out_index, sb_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with all hits asserted, then release with hits low.
      reset = 1'b0;
      hit   = '1;
      tick(); tick(); tick();
      reset = 1'b1;
      hit   = '0;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_count", rpt_count, 32'd0);
      tick(); tick();
      chk("rst_busy_after", 32'(busy), 32'd0);
      chk("rst_valid_after", 32'(out_valid), 32'd0);

      // Single hit on group 1 bit 1 with two-edge latency.
      hit[flat_pos(1, 1, SRC_W)] = 1'b1;
      push(BASE + 7);
      tick();
      hit = '0;
      chk("single_valid_e1", 32'(out_valid), 32'd0);
      chk("single_busy_e1", 32'(busy), 32'd1);
      tick();
      chk("single_valid_e2", 32'(out_valid), 32'd1);
      chk("single_index_e2", out_index, 32'd107);
      tick();
      chk("single_valid_e3", 32'(out_valid), 32'd0);
      chk("single_busy_e3", 32'(busy), 32'd0);
      chk("single_count", rpt_count, 32'd1);

      // Grant bit 19 so the pointer sits at 20, then wrap through {2,21,23}.
      hit[19] = 1'b1;
      push(BASE + 19);
      tick();
      hit = '0;
      hit[2] = 1'b1; hit[21] = 1'b1; hit[23] = 1'b1;
      push(BASE + 21);
      push(BASE + 23);
      push(BASE + 2);
      tick();
      hit = '0;
      chk("rr_first_index", out_index, 32'd119);
      drain("rr");
      chk("rr_count", rpt_count, 32'(exp_cnt));

      // Back-pressure from a fresh pointer.
      do_reset();
      chk("bp_reset_count", rpt_count, 32'd0);
      out_ready = 1'b0;
      hit[0] = 1'b1; hit[5] = 1'b1;
      push(BASE + 0);
      push(BASE + 5);
      tick();
      hit = '0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_hold_index", out_index, 32'd100);
         tick();
      end
      out_ready = 1'b1;
      tick();
      chk("bp_b2b_valid", 32'(out_valid), 32'd1);
      chk("bp_b2b_index", out_index, 32'd105);
      drain("bp");

      // Bit 3 re-hit during its own grant cycle, then hit once more later.
      hit[3] = 1'b1;
      push(BASE + 3);
`ifndef COVER_DEDUP_EN
      push(BASE + 3);
`endif
      tick();
      tick();
      hit = '0;
      chk("sg_index", out_index, 32'd103);
      drain("sg");
      hit[3] = 1'b1;
`ifndef COVER_DEDUP_EN
      push(BASE + 3);
`endif
      tick();
      hit = '0;
      drain("sg_late");
      chk("sg_count", rpt_count, 32'(exp_cnt));

      // Pending raised before disable drains; hits while disabled are dropped.
      hit[10] = 1'b1;
      push(BASE + 10);
      tick();
      enable = 1'b0;
      hit = '0;
      hit[4] = 1'b1; hit[9] = 1'b1;
      tick(); tick(); tick();
      hit    = '0;
      enable = 1'b1;
      drain("en");
      chk("en_count", rpt_count, 32'(exp_cnt));
      chk("en_busy", 32'(busy), 32'd0);

      chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
